bure_mem_responder: RTL and testbench
=====================================

# bure_mem_responder

Memory-side responder for the BureCore instruction and data memory ports. It accepts single-beat read/write requests from a core fetch or load/store stage and serves them from an internal word-addressed RAM, with a programmable number of wait states. It returns exactly one response per accepted request under a valid/ready handshake. One instance serves the instruction port and one serves the data port in the core testbench and FPGA top.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- MEM_DEPTH, 1024, RAM size in DATA_WIDTH words; power of two.
- BASE_ADDR, 0, byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8.
- WAIT_STATES, 0, extra cycles inserted before each access; legal range 0..15.

Ports:
- i_clk  in  1  clock. All logic is on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  responder can accept a request.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_be  in  DATA_WIDTH/8  byte enables; used only for writes.
- i_req_wdata  in  DATA_WIDTH  write data.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  initiator accepts the response.
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors.
- o_rsp_err  out  1  access fault: misaligned or out of range.

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- o_req_ready = (state == IDLE) && !i_rst.
- **IDLE:**
  - On i_req_valid && o_req_ready, capture addr, we, be and wdata.
  - Load the wait counter with WAIT_STATES, then go to WAIT.
- **WAIT:**
  - While the counter is nonzero, decrement it each cycle.
  - When the counter is 0, perform the access, register the response, and go to RESP.
- **RESP:**
  - Hold o_rsp_valid = 1 with o_rsp_rdata and o_rsp_err stable.
  - On i_rsp_ready, go to IDLE.
- **Address decode:**
  - Offset = addr − BASE_ADDR, computed modulo 2^ADDR_WIDTH.
  - Word index = offset >> log2(DATA_WIDTH/8).
  - Misaligned: any of the low log2(DATA_WIDTH/8) bits of addr are nonzero. This sets err.
  - Out of range: offset ≥ MEM_DEPTH*DATA_WIDTH/8, including the unsigned wrap when addr < BASE_ADDR. This sets err.
- **Errored access:** no RAM write, rdata = 0, err = 1.
- **Write:**
  - Only byte lanes with be[i] = 1 are updated.
  - be = 0 is a legal no-op and returns err = 0.
  - The response has rdata = 0.
- **Read:** returns the full word; be is ignored.
- **RAM contents:** not affected by reset. Simulation initialises them to zero. An optional $readmemh file is loaded by the testbench, not by this block.
- Only one transaction is outstanding at a time. No pipelining and no reordering.

## Timing
- **Reset values:** state IDLE, o_req_ready 0 during the reset cycle and 1 in the first cycle after reset, o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0, wait counter 0.
- **Latency:**
  - A request is accepted on edge k.
  - o_rsp_valid rises after edge k+1+WAIT_STATES.
  - With WAIT_STATES = 0, the response is visible 1 cycle after acceptance.
- **Response hold:** if i_rsp_ready is low, o_rsp_valid and the payload stay constant indefinitely.
- **Response completion:**
  - The response completes on the edge where o_rsp_valid && i_rsp_ready.
  - o_req_ready returns to 1 in the next cycle.
  - Maximum throughput is one transaction per 3+WAIT_STATES cycles.
- **Write visibility:** a write is committed on the edge that enters RESP. A read accepted later returns the new data.
- **Request side:** request inputs are sampled only on the accept edge. Changes while o_req_ready = 0 are ignored.
- **Reset mid-transaction:**
  - Reset in WAIT: the pending write is discarded and no response is produced.
  - Reset in RESP: the write was already committed; o_rsp_valid drops in the next cycle.
- **Simultaneous events:** a new i_req_valid during RESP is not accepted until the cycle after the response handshake.

## Test plan
- **Reset, then write and read back (WAIT_STATES = 0):**
  - Write 0xDEADBEEF to 0x10 with be = 0xF, then read 0x10.
  - Required: rdata 0xDEADBEEF, err 0.
  - Required: each rsp_valid appears 1 cycle after its accept.
- **Byte strobes:**
  - Write 0x11223344 to 0x20, then write 0xAABBCCDD with be = 0b0101, then read 0x20.
  - Required: 0x11BB33DD.
- **Faults:**
  - Read 0x22 (misaligned) → err 1, rdata 0.
  - With MEM_DEPTH = 1024, write to 0x1000 (out of range) → err 1, and a subsequent read of 0x0 is unchanged.
- **Wait states and backpressure (WAIT_STATES = 3):**
  - Hold i_rsp_ready low for 5 cycles.
  - Required: rsp_valid rises 4 cycles after accept, payload is stable for all 5 cycles, and o_req_ready is 0 throughout.
- **Reset mid-operation:**
  - Assert i_rst in the WAIT state of a write to 0x30.
  - Required: no response, and a read of 0x30 returns the old value.
- **Randomised back-to-back traffic:**
  - Run 1000 transactions with random rsp_ready against a reference model.
  - Required: every accept yields exactly one response, with matching data.

Source files
------------

// File: rtl/bure_mem_responder.sv
// bure_mem_responder: single-outstanding word RAM responder with programmable wait states
module bure_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_DEPTH = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int WAIT_STATES = 0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_valid,
   output logic o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic i_req_we,
   input  logic [DATA_WIDTH/8-1:0] i_req_be,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic o_rsp_valid,
   input  logic i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic o_rsp_err
);
   localparam int NB = DATA_WIDTH/8;
   localparam int LB = $clog2(NB);
   localparam int IW = $clog2(MEM_DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t state, nxt;
   logic [3:0] cnt;
   logic [ADDR_WIDTH-1:0] addr, offset;
   logic we, fault, access;
   logic [NB-1:0] be;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [IW-1:0] idx;
   // BASE_ADDR is span-aligned, so offset low bits equal addr low bits and any bit above the span
   // (including the wrap below BASE_ADDR) means out of range
   always_comb begin
      offset = addr - BASE_ADDR;
      idx = offset[LB +: IW];
      fault = |offset[LB-1:0] || |offset[ADDR_WIDTH-1:LB+IW];
      access = state == S_WAIT && cnt == 4'd0;
   end
   always_ff @(posedge i_clk)
      if (i_rst) state <= S_IDLE;
      else state <= nxt;
   always_comb
      nxt = (state == S_IDLE && i_req_valid) ? S_WAIT :
            access ? S_RESP :
            (state == S_RESP && i_rsp_ready) ? S_IDLE : state;
   always_comb begin
      o_req_ready = state == S_IDLE && !i_rst;
      o_rsp_valid = state == S_RESP;
   end
   always_ff @(posedge i_clk)
      if (o_req_ready && i_req_valid) begin
         addr <= i_req_addr;
         we <= i_req_we;
         be <= i_req_be;
         wdata <= i_req_wdata;
      end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         cnt <= 4'd0;
         o_rsp_rdata <= '0;
         o_rsp_err <= 1'b0;
      end else if (o_req_ready && i_req_valid) begin
         cnt <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
         cnt <= access ? cnt : cnt - 4'd1;
         if (access) begin
            o_rsp_rdata <= (fault || we) ? '0 : mem[idx];
            o_rsp_err <= fault;
         end
      end
   always_ff @(posedge i_clk)
      if (!i_rst && access && we && !fault)
         for (int i = 0; i < NB; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: tb/tb_bure_mem_responder.sv
// tb_bure_mem_responder: scoreboard bench driving a 0-wait and a 3-wait responder
module tb_bure_mem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst [2];
   logic req_valid [2];
   logic req_ready [2];
   logic req_we [2];
   logic rsp_valid [2];
   logic rsp_ready [2];
   logic rsp_err [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic [31:0] rsp_rdata [2];
   logic [3:0] req_be [2];
   typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
   exp_t sb [$];
   logic [31:0] m [2][1024];
   int checks = 0, passed = 0;
   int acc [2] = '{0, 0};
   int rsps [2] = '{0, 0};

   for (genvar g = 0; g < 2; g++) begin : g_dut
      bure_mem_responder #(.WAIT_STATES(3*g)) u_dut (
         .i_clk(clk), .i_rst(rst[g]), .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]),
         .i_req_addr(req_addr[g]), .i_req_we(req_we[g]), .i_req_be(req_be[g]),
         .i_req_wdata(req_wdata[g]), .o_rsp_valid(rsp_valid[g]), .i_rsp_ready(rsp_ready[g]),
         .o_rsp_rdata(rsp_rdata[g]), .o_rsp_err(rsp_err[g])
      );
   end

   always @(posedge clk) begin
      if (req_valid[0] && req_ready[0]) acc[0] <= acc[0] + 1;
      if (req_valid[1] && req_ready[1]) acc[1] <= acc[1] + 1;
      if (rsp_valid[0] && rsp_ready[0]) rsps[0] <= rsps[0] + 1;
      if (rsp_valid[1] && rsp_ready[1]) rsps[1] <= rsps[1] + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model(input int d, input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, output exp_t e);
      logic f;
      f = a[1:0] != 2'd0 || a >= 32'h1000;
      e.err = f;
      e.rdata = (f || we) ? 32'd0 : m[d][a[11:2]];
      if (!f && we)
         for (int i = 0; i < 4; i++)
            if (be[i]) m[d][a[11:2]][8*i +: 8] = wd[8*i +: 8];
   endtask

   task automatic xact(input int d, input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input int hold);
      exp_t e, s;
      int n;
      @(negedge clk);
      req_valid[d] = 1'b1; req_addr[d] = a; req_we[d] = we; req_be[d] = be; req_wdata[d] = wd;
      model(d, a, we, be, wd, e);
      sb.push_back(e);
      n = 0;
      while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1;
      req_valid[d] = 1'($urandom); req_addr[d] = $urandom; req_we[d] = 1'($urandom);
      req_be[d] = 4'($urandom); req_wdata[d] = $urandom;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid[d] && n < 50);
      check("latency", 64'(n), 64'(2 + 3*d));
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 64'(rsp_valid[d]), 64'd1);
         check("hold_req_ready", 64'(req_ready[d]), 64'd0);
         check("hold_payload", 64'({rsp_rdata[d], rsp_err[d]}), 64'(e));
         @(negedge clk);
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      s = (sb.size() > 0) ? sb.pop_front() : '0;
      check("rsp_payload", 64'({rsp_rdata[d], rsp_err[d]}), 64'(s));
      check("rsp_valid", 64'(rsp_valid[d]), 64'd1);
      @(posedge clk);
      #1;
      rsp_ready[d] = 1'b0;
      @(negedge clk);
      check("done_valid", 64'(rsp_valid[d]), 64'd0);
      check("done_req_ready", 64'(req_ready[d]), 64'd1);
   endtask

   initial begin
      exp_t e;
      logic [31:0] a;
      int d, r;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; req_addr[i] = '0; req_we[i] = 1'b0;
         req_be[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_req_ready", 64'(req_ready[i]), 64'd0);
         check("rst_rsp_valid", 64'(rsp_valid[i]), 64'd0);
         check("rst_rdata", 64'(rsp_rdata[i]), 64'd0);
         check("rst_err", 64'(rsp_err[i]), 64'd0);
         rst[i] = 1'b0;
      end
      @(negedge clk);
      check("post_rst_ready0", 64'(req_ready[0]), 64'd1);
      check("post_rst_ready1", 64'(req_ready[1]), 64'd1);
      for (int i = 0; i < 16; i++) begin
         xact(0, 32'(4*i), 1'b1, 4'hF, 32'd0, 0);
         xact(1, 32'(4*i), 1'b1, 4'hF, 32'd0, 0);
      end
      xact(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 0);
      xact(0, 32'h10, 1'b0, 4'h0, 32'd0, 0);
      xact(0, 32'h20, 1'b1, 4'hF, 32'h11223344, 1);
      xact(0, 32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, 0);
      xact(0, 32'h20, 1'b0, 4'hF, 32'd0, 0);
      xact(0, 32'h22, 1'b0, 4'hF, 32'd0, 0);
      xact(0, 32'h0, 1'b1, 4'hF, 32'h0BADF00D, 0);
      xact(0, 32'h1000, 1'b1, 4'hF, 32'hFFFFFFFF, 0);
      xact(0, 32'h0, 1'b0, 4'hF, 32'd0, 0);
      xact(0, 32'h10, 1'b1, 4'h0, 32'h12345678, 0);
      xact(0, 32'h10, 1'b0, 4'hF, 32'd0, 0);
      xact(1, 32'h14, 1'b1, 4'hF, 32'hCAFEF00D, 0);
      xact(1, 32'h14, 1'b0, 4'hF, 32'd0, 5);
      xact(1, 32'h30, 1'b1, 4'hF, 32'h5A5A0030, 0);
      @(negedge clk);
      req_valid[1] = 1'b1; req_addr[1] = 32'h30; req_we[1] = 1'b1; req_be[1] = 4'hF;
      req_wdata[1] = 32'hBAD0BAD0;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      check("midrst_req_ready", 64'(req_ready[1]), 64'd0);
      rst[1] = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check("midrst_no_rsp", 64'(rsp_valid[1]), 64'd0);
      end
      xact(1, 32'h30, 1'b0, 4'hF, 32'd0, 0);
      for (int t = 0; t < 1000; t++) begin
         d = int'($urandom_range(1));
         r = int'($urandom_range(7));
         a = 32'(4 * $urandom_range(15));
         if (r == 6) a = a + 32'($urandom_range(3, 1));
         else if (r == 7) a = ($urandom_range(1) != 0) ? 32'hFFFFFFFC : 32'h1000 + 32'(4 * $urandom_range(63));
         xact(d, a, 1'($urandom), 4'($urandom), $urandom, int'($urandom_range(3)));
      end
      @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      check("one_rsp_per_accept0", 64'(acc[0]), 64'(rsps[0]));
      check("one_rsp_per_accept1", 64'(acc[1]), 64'(rsps[1] + 1));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
